zebra_detection_filter: RTL and testbench

Temporal filter stage directly downstream of `zebra_crossing_detector`. It consumes the per-frame detection pulse (`detection_valid`, `crossing_detected`, `stripe_count`, `confidence`) and applies an N-of-M sliding-window vote with hysteresis to produce a stable crossing-present flag and a smoothed confidence value. Lock/unlock transitions are reported on a valid/ready event stream for the control processor. A watchdog forces the block back to idle if the detector stops producing frames.

---
 rtl/zebra_pkg.sv | 29 ++
 rtl/zebra_event_slot.sv | 32 +++
 rtl/zebra_detection_filter.sv | 159 +++++++++++++++
 tb/tb_zebra_detection_filter.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/zebra_pkg.sv
// Shared types and helpers for the zebra crossing temporal filter.
package zebra_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        CANDIDATE = 2'd1,
        LOCKED    = 2'd2,
        RELEASING = 2'd3
    } zebra_state_e;

    typedef struct packed {
        logic        rising;
        logic [15:0] conf;
        logic [7:0]  stripes;
        logic [15:0] frame;
    } zebra_evt_t;

    localparam int unsigned EVT_W = $bits(zebra_evt_t);

    // One EMA step: avg - avg/2^s + sample/2^s, saturated to 16 bits.
    function automatic logic [15:0] ema_step(input logic [15:0] avg,
                                             input logic [15:0] sample,
                                             input int unsigned shift);
        logic [16:0] sum;
        sum = 17'(avg) - 17'(avg >> shift) + 17'(sample >> shift);
        return sum[16] ? 16'hFFFF : sum[15:0];
    endfunction

endpackage

// File: rtl/zebra_event_slot.sv
// One-entry valid/ready event register; a load into a full, unread slot
// overwrites it and sets a sticky overflow flag.
module zebra_event_slot
    import zebra_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [EVT_W-1:0] load_evt,
    input  logic             ready,
    output logic             valid,
    output logic [EVT_W-1:0] evt,
    output logic             overflow
);

    always_ff @(posedge clk) begin
        if (rst) begin
            valid    <= 1'b0;
            evt      <= '0;
            overflow <= 1'b0;
        end else if (load) begin
            evt   <= load_evt;
            valid <= 1'b1;
            if (valid && !ready) begin
                overflow <= 1'b1;
            end
        end else if (valid && ready) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/zebra_detection_filter.sv
// N-of-M sliding-window vote with hysteresis over per-frame crossing
// detections, confidence EMA, frame watchdog and lock/unlock event stream.
module zebra_detection_filter
    import zebra_pkg::*;
#(
    parameter int unsigned WINDOW         = 8,
    parameter int unsigned ASSERT_COUNT   = 5,
    parameter int unsigned DEASSERT_COUNT = 2,
    parameter int unsigned TIMEOUT_CYCLES = 2_000_000,
    parameter int unsigned ALPHA_SHIFT    = 3
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         det_valid,
    input  logic                         det_crossing,
    input  logic [7:0]                   det_stripes,
    input  logic [15:0]                  det_confidence,
    output logic                         crossing_active,
    output logic [1:0]                   state,
    output logic [$clog2(WINDOW+1)-1:0]  hit_count,
    output logic [15:0]                  avg_confidence,
    output logic                         stale,
    output logic                         evt_valid,
    input  logic                         evt_ready,
    output logic                         evt_rising,
    output logic [15:0]                  evt_confidence,
    output logic [7:0]                   evt_stripes,
    output logic [15:0]                  evt_frame,
    output logic                         evt_overflow
);

    localparam int unsigned HIT_W = $clog2(WINDOW + 1);
    localparam int unsigned WD_W  = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [HIT_W-1:0] ASSERT_H   = HIT_W'(ASSERT_COUNT);
    localparam logic [HIT_W-1:0] DEASSERT_H = HIT_W'(DEASSERT_COUNT);
    localparam logic [WD_W-1:0]  WD_MAX     = WD_W'(TIMEOUT_CYCLES);

    zebra_state_e      state_q, state_d;
    logic [WINDOW-1:0] hist_q, hist_d, hist_shift;
    logic [HIT_W-1:0]  hit_new, hit_d;
    logic [15:0]       avg_d;
    logic [15:0]       frame_q, frame_d;
    logic [WD_W-1:0]   wd_q, wd_d;
    logic              stale_d;
    logic              wd_fire;
    logic              evt_load;
    zebra_evt_t        evt_new;
    zebra_evt_t        evt_q;

    assign hist_shift = {hist_q[WINDOW-2:0], det_crossing};
    assign hit_new    = HIT_W'($countones(hist_shift));
    // A frame in the terminal cycle wins; stale gating keeps the timeout one-shot.
    assign wd_fire    = !det_valid && !stale && (wd_q == WD_MAX);
    assign state      = state_q;

    always_comb begin
        state_d  = state_q;
        hist_d   = hist_q;
        hit_d    = hit_count;
        avg_d    = avg_confidence;
        frame_d  = frame_q;
        stale_d  = stale;
        wd_d     = wd_q;
        evt_load = 1'b0;
        evt_new  = '0;

        if (det_valid) begin
            wd_d    = '0;
        end else if (wd_q != WD_MAX) begin
            wd_d    = wd_q + WD_W'(1);
        end

        if (det_valid) begin
            hist_d  = hist_shift;
            hit_d   = hit_new;
            frame_d = frame_q + 16'd1;
            avg_d   = ema_step(avg_confidence, det_confidence, ALPHA_SHIFT);
            stale_d = 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (hit_new != '0) state_d = CANDIDATE;
                end
                CANDIDATE: begin
                    if (hit_new >= ASSERT_H) begin
                        state_d        = LOCKED;
                        evt_load       = 1'b1;
                        evt_new.rising = 1'b1;
                    end else if (hit_new == '0) begin
                        state_d = IDLE;
                    end
                end
                LOCKED: begin
                    if (hit_new <= DEASSERT_H) state_d = RELEASING;
                end
                RELEASING: begin
                    if (hit_new > DEASSERT_H) begin
                        state_d = LOCKED;
                    end else begin
                        state_d  = (hit_new == '0) ? IDLE : CANDIDATE;
                        evt_load = 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
            evt_new.conf    = avg_d;
            evt_new.stripes = det_stripes;
            evt_new.frame   = frame_d;
        end else if (wd_fire) begin
            hist_d  = '0;
            hit_d   = '0;
            state_d = IDLE;
            stale_d = 1'b1;
            if (state_q == LOCKED || state_q == RELEASING) begin
                evt_load = 1'b1;
            end
            evt_new.conf  = avg_confidence;
            evt_new.frame = frame_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= IDLE;
            hist_q          <= '0;
            hit_count       <= '0;
            avg_confidence  <= '0;
            frame_q         <= '0;
            wd_q            <= '0;
            stale           <= 1'b0;
            crossing_active <= 1'b0;
        end else begin
            state_q         <= state_d;
            hist_q          <= hist_d;
            hit_count       <= hit_d;
            avg_confidence  <= avg_d;
            frame_q         <= frame_d;
            wd_q            <= wd_d;
            stale           <= stale_d;
            crossing_active <= (state_d == LOCKED) || (state_d == RELEASING);
        end
    end

    zebra_event_slot u_slot (
        .clk      (clk),
        .rst      (rst),
        .load     (evt_load),
        .load_evt (evt_new),
        .ready    (evt_ready),
        .valid    (evt_valid),
        .evt      (evt_q),
        .overflow (evt_overflow)
    );

    assign evt_rising     = evt_q.rising;
    assign evt_confidence = evt_q.conf;
    assign evt_stripes    = evt_q.stripes;
    assign evt_frame      = evt_q.frame;

endmodule

// File: tb/tb_zebra_detection_filter.sv
// Directed bench for zebra_detection_filter: reference model plus event scoreboard.
module tb_zebra_detection_filter;
    import zebra_pkg::*;

    localparam int unsigned TO = 1000;

    logic        clk = 1'b0;
    logic        rst;
    logic        det_valid, det_crossing;
    logic [7:0]  det_stripes;
    logic [15:0] det_confidence;
    logic        crossing_active;
    logic [1:0]  state;
    logic [3:0]  hit_count;
    logic [15:0] avg_confidence;
    logic        stale;
    logic        evt_valid, evt_ready, evt_rising, evt_overflow;
    logic [15:0] evt_confidence, evt_frame;
    logic [7:0]  evt_stripes;

    zebra_detection_filter #(
        .WINDOW(8), .ASSERT_COUNT(5), .DEASSERT_COUNT(2),
        .TIMEOUT_CYCLES(TO), .ALPHA_SHIFT(3)
    ) dut (
        .clk(clk), .rst(rst),
        .det_valid(det_valid), .det_crossing(det_crossing),
        .det_stripes(det_stripes), .det_confidence(det_confidence),
        .crossing_active(crossing_active), .state(state), .hit_count(hit_count),
        .avg_confidence(avg_confidence), .stale(stale),
        .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_rising(evt_rising),
        .evt_confidence(evt_confidence), .evt_stripes(evt_stripes),
        .evt_frame(evt_frame), .evt_overflow(evt_overflow)
    );

    always #5 clk = ~clk;

    zebra_evt_t   q[$];
    int           n_vec = 0;
    int           n_err = 0;
    logic [7:0]   m_hist;
    zebra_state_e m_state;
    logic [15:0]  m_avg, m_frame;
    logic         m_ovf, m_stale;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic zebra_evt_t dut_evt();
        zebra_evt_t e;
        e.rising  = evt_rising;
        e.conf    = evt_confidence;
        e.stripes = evt_stripes;
        e.frame   = evt_frame;
        return e;
    endfunction

    task automatic model_reset();
        m_hist = '0; m_state = IDLE; m_avg = '0; m_frame = '0;
        m_ovf = 1'b0; m_stale = 1'b0;
        q.delete();
    endtask

    // A load into an unread slot with ready low replaces the pending entry.
    task automatic model_push(input zebra_evt_t e);
        if (!evt_ready && q.size() != 0) begin
            void'(q.pop_back());
            m_ovf = 1'b1;
        end
        q.push_back(e);
    endtask

    task automatic check_outputs(input string tag);
        chk({tag, ".state"}, 64'(state), 64'(m_state));
        chk({tag, ".hit_count"}, 64'(hit_count), 64'($countones(m_hist)));
        chk({tag, ".avg"}, 64'(avg_confidence), 64'(m_avg));
        chk({tag, ".active"}, 64'(crossing_active),
            64'(m_state == LOCKED || m_state == RELEASING));
        chk({tag, ".stale"}, 64'(stale), 64'(m_stale));
        chk({tag, ".overflow"}, 64'(evt_overflow), 64'(m_ovf));
        chk({tag, ".evt_valid"}, 64'(evt_valid), 64'(q.size() != 0));
        if (q.size() != 0) chk({tag, ".evt_payload"}, 64'(dut_evt()), 64'(q[0]));
    endtask

    task automatic frame(input logic c, input logic [7:0] s, input logic [15:0] conf);
        int         a;
        int         h;
        logic       ev;
        zebra_evt_t e;
        @(negedge clk);
        det_valid = 1'b1; det_crossing = c; det_stripes = s; det_confidence = conf;
        m_hist  = {m_hist[6:0], c};
        h       = $countones(m_hist);
        m_frame = m_frame + 16'd1;
        a = int'(m_avg);
        a = a - a / 8 + int'(conf) / 8;
        if (a > 65535) a = 65535;
        m_avg   = 16'(a);
        m_stale = 1'b0;
        ev = 1'b0;
        e  = '0;
        case (m_state)
            IDLE:      if (h >= 1) m_state = CANDIDATE;
            CANDIDATE: if (h >= 5) begin m_state = LOCKED; ev = 1'b1; e.rising = 1'b1; end
                       else if (h == 0) m_state = IDLE;
            LOCKED:    if (h <= 2) m_state = RELEASING;
            default:   if (h > 2) m_state = LOCKED;
                       else begin m_state = (h == 0) ? IDLE : CANDIDATE; ev = 1'b1; end
        endcase
        e.conf = m_avg; e.stripes = s; e.frame = m_frame;
        if (ev) model_push(e);
        @(posedge clk); #1;
        det_valid = 1'b0;
        check_outputs("frame");
    endtask

    task automatic check_zero(input string tag);
        chk({tag, ".state"}, 64'(state), 64'(IDLE));
        chk({tag, ".hit_count"}, 64'(hit_count), 64'd0);
        chk({tag, ".avg"}, 64'(avg_confidence), 64'd0);
        chk({tag, ".stale"}, 64'(stale), 64'd0);
        chk({tag, ".active"}, 64'(crossing_active), 64'd0);
        chk({tag, ".evt_valid"}, 64'(evt_valid), 64'd0);
        chk({tag, ".overflow"}, 64'(evt_overflow), 64'd0);
        chk({tag, ".evt_payload"}, 64'(dut_evt()), 64'd0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        check_zero("reset");
        model_reset();
        rst = 1'b0;
    endtask

    // Scoreboard: each handshake pops the oldest expected event.
    always @(negedge clk) begin
        if (!rst && evt_valid && evt_ready) begin
            n_vec++;
            assert (q.size() != 0) else begin
                n_err++;
                $error("FAIL evt_unexpected: observed %0h expected none", dut_evt());
            end
            if (q.size() != 0) chk("evt_handshake", 64'(dut_evt()), 64'(q.pop_front()));
        end
    end

    initial begin
        logic [25:0] pat;
        zebra_evt_t  te;
        rst = 1'b1; det_valid = 1'b0; det_crossing = 1'b0;
        det_stripes = '0; det_confidence = '0; evt_ready = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_zero("cold_reset");
        rst = 1'b0;

        // Lock after five hits; rising event carries frame 5.
        evt_ready = 1'b1;
        for (int i = 0; i < 5; i++) frame(1'b1, 8'(10 + i), 16'(1000 + i * 37));
        chk("lock.evt_frame", 64'(evt_frame), 64'd5);
        chk("lock.evt_rising", 64'(evt_rising), 64'd1);

        // Hysteresis: release, fall to candidate, relock, bounce, fall.
        pat = 26'b111_000000_0_11111_01001000100;
        for (int i = 25; i >= 0; i--) frame(pat[i], 8'(i), 16'(2000 + i * 53));

        // Watchdog expiry from lock.
        do_reset();
        for (int i = 0; i < 5; i++) frame(1'b1, 8'(i), 16'd4000);
        repeat (TO) @(posedge clk);
        #1;
        chk("wd.before_stale", 64'(stale), 64'd0);
        chk("wd.before_state", 64'(state), 64'(LOCKED));
        te.rising = 1'b0; te.conf = m_avg; te.stripes = 8'd0; te.frame = m_frame;
        model_push(te);
        m_hist = '0; m_state = IDLE; m_stale = 1'b1;
        @(posedge clk); #1;
        check_outputs("wd_fire");
        frame(1'b1, 8'd7, 16'd4000);
        // Frame exactly in the terminal cycle suppresses the timeout.
        repeat (TO) @(posedge clk);
        frame(1'b1, 8'd8, 16'd4000);
        @(posedge clk); #1;
        chk("wd.terminal_stale", 64'(stale), 64'd0);
        chk("wd.terminal_state", 64'(state), 64'(m_state));

        // EMA convergence toward a constant input.
        do_reset();
        for (int i = 0; i < 100; i++) begin
            frame(1'b0, 8'd0, 16'd800);
            chk("ema.le_800", 64'(avg_confidence <= 16'd800), 64'd1);
        end
        chk("ema.converged", 64'(avg_confidence >= 16'd792 && avg_confidence <= 16'd808), 64'd1);

        // Overwrite of an unread rising event by a falling event.
        do_reset();
        evt_ready = 1'b0;
        for (int i = 0; i < 5; i++) frame(1'b1, 8'(i), 16'd500);
        for (int i = 0; i < 7; i++) frame(1'b0, 8'(20 + i), 16'd500);
        chk("ovf.set", 64'(evt_overflow), 64'd1);
        chk("ovf.rising", 64'(evt_rising), 64'd0);

        // Same sequence, ready pulsed in the load cycle: no overflow.
        do_reset();
        evt_ready = 1'b0;
        for (int i = 0; i < 5; i++) frame(1'b1, 8'(i), 16'd500);
        for (int i = 0; i < 6; i++) frame(1'b0, 8'(20 + i), 16'd500);
        evt_ready = 1'b1;
        frame(1'b0, 8'd99, 16'd500);
        evt_ready = 1'b0;
        chk("ovf.clear", 64'(evt_overflow), 64'd0);
        chk("ovf.pending_falling", 64'(evt_valid && !evt_rising), 64'd1);

        // Reset while locked with an event pending, then cold-start behaviour.
        do_reset();
        for (int i = 0; i < 5; i++) frame(1'b1, 8'(i), 16'd300);
        do_reset();
        evt_ready = 1'b1;
        for (int i = 0; i < 5; i++) frame(1'b1, 8'(40 + i), 16'd300);
        chk("restart.evt_frame", 64'(evt_frame), 64'd5);

        @(posedge clk); #1;
        evt_ready = 1'b0;
        chk("drain.queue", 64'(q.size()), 64'd0);
        chk("drain.evt_valid", 64'(evt_valid), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
